// File: rtl/vai_regfile.sv
// vai_regfile: framed register-file access block.
// An input frame (header, optional length or data words) reads or writes a
// small register file; every frame is answered with header, read data (if
// any) and a footer carrying the error flags.
module vai_regfile #(
  parameter int DATA_W    = 8,
  parameter int REG_NUM   = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                      Clk_i,
  input  logic                      Reset_i,
  input  logic [DATA_W-1:0]         Din_i,
  input  logic                      DinValid_i,
  input  logic                      DinStart_i,
  input  logic                      DinStop_i,
  output logic                      DinAccept_o,
  output logic [DATA_W-1:0]         Dout_o,
  output logic                      DoutValid_o,
  output logic                      DoutStart_o,
  output logic                      DoutStop_o,
  input  logic                      DoutAccept_i,
  output logic [REG_NUM*DATA_W-1:0] Reg_o
);

  localparam int ADDR_W = DATA_W - 4;
  // One spare bit so the pointer can saturate above any legal address.
  localparam int PTR_W  = ADDR_W + 1;
  localparam int IDX_W  = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam int CNT_W  = $clog2(MAX_BURST + 1);
  localparam int LEN_W  = (DATA_W > CNT_W) ? DATA_W : CNT_W;

  localparam logic [PTR_W-1:0] REG_LIM     = PTR_W'(REG_NUM);
  localparam logic [CNT_W-1:0] BURST_LIM   = CNT_W'(MAX_BURST);
  localparam logic [LEN_W-1:0] BURST_LIM_L = LEN_W'(MAX_BURST);
  localparam logic [3:0]       CMD_READ    = 4'd0;
  localparam logic [3:0]       CMD_WRITE   = 4'd1;

  typedef enum logic [2:0] {
    GET_HEADER  = 3'd0,
    GET_LEN     = 3'd1,
    SET_DATA    = 3'd2,
    DISCARD     = 3'd3,
    SEND_HEADER = 3'd4,
    SEND_DATA   = 3'd5,
    SEND_FOOTER = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   hdr_q, hdr_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic                err_frame_q, err_frame_d;
  logic                err_len_q, err_len_d;
  logic                err_cmd_q, err_cmd_d;
  logic                err_addr_q, err_addr_d;
  logic                wr_en;
  logic [DATA_W-1:0]   regs_q [REG_NUM];

  logic                in_st;
  logic                out_st;
  logic                din_take;
  logic                dout_take;
  logic                ptr_ok;
  logic [LEN_W-1:0]    din_len;
  logic [CNT_W-1:0]    cnt_inc;
  logic [PTR_W-1:0]    ptr_inc;
  logic [DATA_W-1:0]   rd_word;

  function automatic logic [PTR_W-1:0] sat_inc_ptr(input logic [PTR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v >= BURST_LIM) ? v : v + 1'b1;
  endfunction

  assign in_st     = ((state_q == GET_HEADER) || (state_q == GET_LEN) ||
                      (state_q == SET_DATA)   || (state_q == DISCARD)) && !Reset_i;
  assign out_st    = (state_q == SEND_HEADER) || (state_q == SEND_DATA) ||
                     (state_q == SEND_FOOTER);
  assign DinAccept_o = in_st;
  assign din_take  = DinValid_i && in_st;
  assign dout_take = DoutAccept_i && out_st;
  assign ptr_ok    = ptr_q < REG_LIM;
  assign din_len   = LEN_W'(Din_i);
  assign cnt_inc   = sat_inc_cnt(cnt_q);
  assign ptr_inc   = sat_inc_ptr(ptr_q);
  assign rd_word   = ptr_ok ? regs_q[ptr_q[IDX_W-1:0]] : '0;

  // Next-state, frame bookkeeping and response word selection.
  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    err_frame_d = err_frame_q;
    err_len_d   = err_len_q;
    err_cmd_d   = err_cmd_q;
    err_addr_d  = err_addr_q;
    wr_en       = 1'b0;
    Dout_o      = '0;
    DoutValid_o = 1'b0;
    DoutStart_o = 1'b0;
    DoutStop_o  = 1'b0;
    case (state_q)
      GET_HEADER: begin
        if (din_take && DinStart_i) begin
          hdr_d       = Din_i;
          ptr_d       = {1'b0, Din_i[DATA_W-1:4]};
          cnt_d       = '0;
          len_d       = '0;
          err_frame_d = 1'b0;
          err_len_d   = 1'b0;
          err_cmd_d   = 1'b0;
          err_addr_d  = 1'b0;
          if (Din_i[3:0] == CMD_READ) begin
            if (DinStop_i) begin
              len_d   = CNT_W'(1);
              state_d = SEND_HEADER;
            end else begin
              state_d = GET_LEN;
            end
          end else if (Din_i[3:0] == CMD_WRITE) begin
            if (DinStop_i) begin
              err_frame_d = 1'b1;
              state_d     = SEND_HEADER;
            end else begin
              state_d = SET_DATA;
            end
          end else begin
            err_cmd_d = 1'b1;
            state_d   = DinStop_i ? SEND_HEADER : DISCARD;
          end
        end
      end
      GET_LEN: begin
        if (din_take) begin
          if (din_len == '0) begin
            err_len_d = 1'b1;
            len_d     = '0;
          end else if (din_len > BURST_LIM_L) begin
            err_len_d = 1'b1;
            len_d     = BURST_LIM;
          end else begin
            len_d = CNT_W'(din_len);
          end
          if (DinStop_i) begin
            state_d = SEND_HEADER;
          end else begin
            err_frame_d = 1'b1;
            state_d     = DISCARD;
          end
        end
      end
      SET_DATA: begin
        if (din_take) begin
          wr_en = (cnt_q < BURST_LIM) && ptr_ok;
          if (!ptr_ok)             err_addr_d = 1'b1;
          if (cnt_q == BURST_LIM)  err_len_d  = 1'b1;
          ptr_d = ptr_inc;
          cnt_d = cnt_inc;
          if (DinStop_i) state_d = SEND_HEADER;
        end
      end
      DISCARD: begin
        if (din_take && DinStop_i) state_d = SEND_HEADER;
      end
      SEND_HEADER: begin
        DoutValid_o = 1'b1;
        DoutStart_o = 1'b1;
        Dout_o      = hdr_q;
        if (dout_take) begin
          cnt_d = '0;
          if ((hdr_q[3:0] == CMD_READ) && (len_q != '0) && !err_cmd_q)
            state_d = SEND_DATA;
          else
            state_d = SEND_FOOTER;
        end
      end
      SEND_DATA: begin
        DoutValid_o = 1'b1;
        Dout_o      = rd_word;
        if (dout_take) begin
          if (!ptr_ok) err_addr_d = 1'b1;
          ptr_d = ptr_inc;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = SEND_FOOTER;
        end
      end
      SEND_FOOTER: begin
        DoutValid_o = 1'b1;
        DoutStop_o  = 1'b1;
        Dout_o      = DATA_W'({err_frame_q, err_len_q, err_cmd_q, err_addr_q});
        if (dout_take) state_d = GET_HEADER;
      end
      default: begin
        state_d = GET_HEADER;
      end
    endcase
  end

  // Control state and frame context registers.
  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q     <= GET_HEADER;
      hdr_q       <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      err_frame_q <= 1'b0;
      err_len_q   <= 1'b0;
      err_cmd_q   <= 1'b0;
      err_addr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      err_frame_q <= err_frame_d;
      err_len_q   <= err_len_d;
      err_cmd_q   <= err_cmd_d;
      err_addr_q  <= err_addr_d;
    end
  end

  // Register file: cleared by reset, written only by accepted in-range SET_DATA words.
  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      for (int k = 0; k < REG_NUM; k++) regs_q[k] <= '0;
    end else if (wr_en) begin
      regs_q[ptr_q[IDX_W-1:0]] <= Din_i;
    end
  end

  // Flattened register view.
  always_comb begin
    Reg_o = '0;
    for (int k = 0; k < REG_NUM; k++) Reg_o[k*DATA_W +: DATA_W] = regs_q[k];
  end

endmodule

// File: tb/tb_vai_regfile.sv
// tb_vai_regfile: directed frames against a frame-level model of vai_regfile.
module tb_vai_regfile;
  localparam int DW = 8;
  localparam int RN = 8;
  localparam int MB = 4;

  logic            Clk = 1'b0;
  logic            Reset;
  logic [DW-1:0]   Din;
  logic            DinValid, DinStart, DinStop, DinAccept;
  logic [DW-1:0]   Dout;
  logic            DoutValid, DoutStart, DoutStop, DoutAccept;
  logic [RN*DW-1:0] RegFlat;

  always #5 Clk = ~Clk;

  vai_regfile #(.DATA_W(DW), .REG_NUM(RN), .MAX_BURST(MB)) dut (
    .Clk_i(Clk), .Reset_i(Reset), .Din_i(Din), .DinValid_i(DinValid),
    .DinStart_i(DinStart), .DinStop_i(DinStop), .DinAccept_o(DinAccept),
    .Dout_o(Dout), .DoutValid_o(DoutValid), .DoutStart_o(DoutStart),
    .DoutStop_o(DoutStop), .DoutAccept_i(DoutAccept), .Reg_o(RegFlat)
  );

  // word layout: [9:2] data, [1] start, [0] stop
  typedef logic [9:0] word_t;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  mreg [RN];
  word_t       exp_q[$];
  word_t       rsp_q[$];
  logic [7:0]  fr[$];
  logic [7:0]  lit[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s (bound expired or unexpected event)", nm);
  endtask

  function automatic logic [RN*DW-1:0] pack_model();
    logic [RN*DW-1:0] v;
    v = '0;
    for (int k = 0; k < RN; k++) v[k*DW +: DW] = mreg[k];
    return v;
  endfunction

  // Frame-level model: derives register effects and the full response of fr.
  task automatic model_frame();
    logic [7:0] hdr;
    logic [3:0] cmd;
    int a, n, len, p;
    logic fe, le, ce, ae;
    n = fr.size(); hdr = fr[0]; cmd = hdr[3:0]; a = int'(hdr[7:4]);
    fe = 0; le = 0; ce = 0; ae = 0; len = 0;
    if (cmd == 4'd0) begin
      if (n == 1) len = 1;
      else begin
        if (fr[1] == 0) begin le = 1; len = 0; end
        else if (fr[1] > MB) begin le = 1; len = MB; end
        else len = int'(fr[1]);
        if (n > 2) fe = 1;
      end
    end else if (cmd == 4'd1) begin
      if (n == 1) fe = 1;
      for (int j = 0; j < n - 1; j++) begin
        p = a + j;
        if (j >= MB) le = 1;
        else if (p < RN) mreg[p] = fr[j+1];
        if (p >= RN) ae = 1;
      end
    end else begin
      ce = 1;
    end
    exp_q.push_back({hdr, 1'b1, 1'b0});
    for (int i = 0; i < len; i++) begin
      p = a + i;
      if (p < RN) exp_q.push_back({mreg[p], 1'b0, 1'b0});
      else begin exp_q.push_back({8'h00, 1'b0, 1'b0}); ae = 1; end
    end
    exp_q.push_back({4'h0, fe, le, ce, ae, 1'b0, 1'b1});
  endtask

  // Output compare: words in order, stability while stalled, no gaps, regs vs model.
  logic  held_v = 1'b0;
  word_t held;
  logic  gap_pend = 1'b0;
  word_t cur;
  always @(negedge Clk) begin
    if (gap_pend) chk("no_gap", DoutValid, 1'b1);
    gap_pend = 1'b0;
    if (!Reset && DoutValid) begin
      cur = {Dout, DoutStart, DoutStop};
      if (held_v) chk("hold_stable", cur, held);
      chk("start_stop_excl", DoutStart & DoutStop, 1'b0);
      chk("regs_vs_model", RegFlat, pack_model());
      if (DoutAccept) begin
        if (exp_q.size() == 0) fail_now("unexpected_word");
        else begin
          chk("dout_word", cur, exp_q[0]);
          void'(exp_q.pop_front());
        end
        rsp_q.push_back(cur);
        held_v = 1'b0;
        gap_pend = !DoutStop;
      end else begin
        held = cur;
        held_v = 1'b1;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic send_word(input logic [7:0] d, input logic s, input logic e);
    int t;
    DinValid = 1'b1; Din = d; DinStart = s; DinStop = e;
    t = 0;
    @(negedge Clk);
    while (!DinAccept && t < 50) begin @(negedge Clk); t++; end
    if (t >= 50) fail_now("din_timeout");
    @(posedge Clk); #1;
    DinValid = 1'b0; DinStart = 1'b0; DinStop = 1'b0; Din = '0;
  endtask

  task automatic drain(input int hold);
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 200) begin
      if (hold > 0) begin
        DoutAccept = 1'b0;
        repeat (hold) @(posedge Clk);
        #1;
      end
      DoutAccept = 1'b1;
      @(posedge Clk); #1;
      t++;
    end
    DoutAccept = 1'b0;
    if (exp_q.size() != 0) begin
      fail_now("dout_timeout");
      exp_q.delete();
    end
  endtask

  task automatic send_frame(input int hold);
    model_frame();
    rsp_q.delete();
    for (int i = 0; i < fr.size(); i++)
      send_word(fr[i], i == 0, i == fr.size() - 1);
    chk("hdr_latency", DoutValid, 1'b1);
    drain(hold);
    chk("back_to_idle", DinAccept, 1'b1);
  endtask

  task automatic chk_lit(input string nm);
    chk({nm, "_len"}, rsp_q.size(), lit.size());
    for (int i = 0; i < lit.size(); i++)
      if (i < rsp_q.size()) chk(nm, rsp_q[i][9:2], lit[i]);
  endtask

  initial begin
    Reset = 1'b1; Din = '0; DinValid = 0; DinStart = 0; DinStop = 0; DoutAccept = 0;
    for (int k = 0; k < RN; k++) mreg[k] = 8'h00;
    #2;
    chk("rst_accept", DinAccept, 1'b0);
    chk("rst_valid", DoutValid, 1'b0);
    chk("rst_dout", {Dout, DoutStart, DoutStop}, 10'h000);
    chk("rst_regs", RegFlat, 64'h0);
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    #1 chk("idle_accept", DinAccept, 1'b1);

    fr = '{8'h21, 8'hAA, 8'hBB};             send_frame(0);
    lit = '{8'h21, 8'h00};                   chk_lit("wr_basic");
    chk("reg2", RegFlat[2*8 +: 8], 8'hAA);
    chk("reg3", RegFlat[3*8 +: 8], 8'hBB);

    fr = '{8'h20, 8'h03};                    send_frame(5);
    lit = '{8'h20, 8'hAA, 8'hBB, 8'h00, 8'h00}; chk_lit("rd_stall");

    fr = '{8'h71, 8'h11, 8'h22};             send_frame(0);
    lit = '{8'h71, 8'h01};                   chk_lit("wr_addr_err");
    chk("reg7", RegFlat[7*8 +: 8], 8'h11);
    fr = '{8'h90};                           send_frame(1);
    lit = '{8'h90, 8'h00, 8'h01};            chk_lit("rd_addr_err");

    fr = '{8'h00, 8'h09};                    send_frame(0);
    lit = '{8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'h04}; chk_lit("rd_len_clamp");
    fr = '{8'h00, 8'h00};                    send_frame(0);
    lit = '{8'h00, 8'h04};                   chk_lit("rd_len_zero");

    fr = '{8'h05, 8'h33, 8'h44};             send_frame(0);
    lit = '{8'h05, 8'h02};                   chk_lit("bad_cmd");
    fr = '{8'h11};                           send_frame(0);
    lit = '{8'h11, 8'h08};                   chk_lit("wr_no_data");

    fr = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05}; send_frame(0);
    lit = '{8'h01, 8'h04};                   chk_lit("wr_burst_over");
    chk("reg0", RegFlat[0 +: 8], 8'h01);
    send_word(8'h20, 1'b0, 1'b1);
    chk("stray_dropped", DoutValid, 1'b0);
    fr = '{8'h00, 8'h02};                    send_frame(2);
    lit = '{8'h00, 8'h01, 8'h02, 8'h00};     chk_lit("rd_after_burst");

    send_word(8'h21, 1'b1, 1'b0);
    send_word(8'hAA, 1'b0, 1'b0);
    Reset = 1'b1;
    for (int k = 0; k < RN; k++) mreg[k] = 8'h00;
    exp_q.delete();
    #1;
    chk("midrst_regs", RegFlat, 64'h0);
    chk("midrst_accept", DinAccept, 1'b0);
    chk("midrst_dout", {Dout, DoutValid, DoutStart, DoutStop}, 11'h000);
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    #1 chk("post_rst_accept", DinAccept, 1'b1);
    @(posedge Clk); #1;
    fr = '{8'h31, 8'h5A};                    send_frame(0);
    lit = '{8'h31, 8'h00};                   chk_lit("post_rst_wr");
    chk("reg3_post", RegFlat[3*8 +: 8], 8'h5A);
    chk("reg2_post", RegFlat[2*8 +: 8], 8'h00);
    fr = '{8'h30};                           send_frame(3);
    lit = '{8'h30, 8'h5A, 8'h00};            chk_lit("post_rst_rd");

    repeat (3) @(posedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
